// File: rtl/console_writer_if.sv
// console_writer_if: character-source and VRAM-write-port bundle for console_writer.
//   master: drives char_i/char_valid_i, observes ready, VRAM write port, cursor and busy.
//   slave : the console_writer side.
interface console_writer_if #(parameter int ADDR_W = 11, parameter int XW = 6, parameter int YW = 5);
  logic [7:0] char_i;
  logic char_valid_i;
  logic char_ready_o;
  logic we_vram;
  logic [ADDR_W-1:0] addr_vram;
  logic [7:0] data_vram;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic busy;
  modport master (output char_i, char_valid_i,
                  input char_ready_o, we_vram, addr_vram, data_vram, cursor_x, cursor_y, busy);
  modport slave (input char_i, char_valid_i,
                 output char_ready_o, we_vram, addr_vram, data_vram, cursor_x, cursor_y, busy);
endinterface

// File: rtl/console_writer.sv
// console_writer: writes ASCII text into console VRAM at a tracked cursor, handling LF/CR/BS/FF.
//   px_clk : only clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : console_writer_if.slave (char valid/ready in, VRAM write port, cursor, busy out)
//   Optional CONSOLE_AUTOCLEAR_EN: every row advance blanks the destination row before accepting more input.
module console_writer #(
  parameter int screenW = 40,
  parameter int screenH = 30,
  parameter int ADDR_W = 11,
  parameter logic [7:0] BLANK = 8'h20
) (
  input logic px_clk,
  input logic reset,
  console_writer_if.slave bus
);
  localparam int XW = $clog2(screenW);
  localparam int YW = $clog2(screenH);
  localparam int CELLS = screenW * screenH;
  typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;
  state_t state, state_n, adv_state;
  logic [XW-1:0] cx, cx_n;
  logic [YW-1:0] cy, cy_n, cy_adv;
  logic we, we_n;
  logic [ADDR_W-1:0] addr, addr_n, line_end;
  logic [7:0] data, data_n;
  logic take, printable, last_col;
  assign take = bus.char_valid_i && state == IDLE;
  assign printable = bus.char_i >= 8'h20 && bus.char_i <= 8'h7E;
  assign last_col = cx == XW'(screenW - 1);
  assign cy_adv = (cy == YW'(screenH - 1)) ? '0 : cy + YW'(1);
  assign line_end = ADDR_W'(cy) * ADDR_W'(screenW) + ADDR_W'(screenW - 1);
`ifdef CONSOLE_AUTOCLEAR_EN
  assign adv_state = CLR_LINE;
`else
  assign adv_state = IDLE;
`endif
  always_ff @(posedge px_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cx <= '0;
      cy <= '0;
      we <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      state <= state_n;
      cx <= cx_n;
      cy <= cy_n;
      we <= we_n;
      addr <= addr_n;
      data <= data_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (take) state_n = printable ? WRITE : bus.char_i == 8'h0A ? adv_state : bus.char_i == 8'h0C ? CLR_ALL : IDLE;
      WRITE: state_n = last_col ? adv_state : IDLE;
      CLR_LINE: state_n = addr == line_end ? IDLE : CLR_LINE;
      CLR_ALL: state_n = addr == ADDR_W'(CELLS - 1) ? IDLE : CLR_ALL;
      default: state_n = IDLE;
    endcase
  end
  // Next values for the registered cursor and VRAM port; the clear states walk addr upward.
  always_comb begin
    cx_n = cx;
    cy_n = cy;
    we_n = 1'b0;
    addr_n = addr;
    data_n = data;
    case (state)
      IDLE: if (take) begin
        if (printable) begin
          we_n = 1'b1;
          addr_n = ADDR_W'(cy) * ADDR_W'(screenW) + ADDR_W'(cx);
          data_n = bus.char_i;
        end else if (bus.char_i == 8'h0A) begin
          cx_n = '0;
          cy_n = cy_adv;
`ifdef CONSOLE_AUTOCLEAR_EN
          we_n = 1'b1;
          addr_n = ADDR_W'(cy_adv) * ADDR_W'(screenW);
          data_n = BLANK;
`endif
        end else if (bus.char_i == 8'h0D) begin
          cx_n = '0;
        end else if (bus.char_i == 8'h08) begin
          cx_n = (cx != '0) ? cx - XW'(1) : cx;
        end else if (bus.char_i == 8'h0C) begin
          we_n = 1'b1;
          addr_n = '0;
          data_n = BLANK;
        end
      end
      WRITE: begin
        cx_n = last_col ? '0 : cx + XW'(1);
        cy_n = last_col ? cy_adv : cy;
`ifdef CONSOLE_AUTOCLEAR_EN
        if (last_col) begin
          we_n = 1'b1;
          addr_n = ADDR_W'(cy_adv) * ADDR_W'(screenW);
          data_n = BLANK;
        end
`endif
      end
      CLR_LINE: if (addr != line_end) begin
        we_n = 1'b1;
        addr_n = addr + ADDR_W'(1);
      end
      CLR_ALL: if (addr != ADDR_W'(CELLS - 1)) begin
        we_n = 1'b1;
        addr_n = addr + ADDR_W'(1);
      end else begin
        cx_n = '0;
        cy_n = '0;
      end
      default: ;
    endcase
  end
  assign bus.char_ready_o = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.we_vram = we;
  assign bus.addr_vram = addr;
  assign bus.data_vram = data;
  assign bus.cursor_x = cx;
  assign bus.cursor_y = cy;
endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer: directed self-checking bench for console_writer.
module tb_console_writer;
  logic px_clk;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  console_writer_if #(.ADDR_W(11), .XW(6), .YW(5)) bus ();
  console_writer dut (.px_clk(px_clk), .reset(reset), .bus(bus));
  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic send(input logic [7:0] c);
    int t;
    t = 0;
    while (!bus.char_ready_o && t < 2000) begin
      @(posedge px_clk); #1;
      t++;
    end
    if (t >= 2000) begin
      n_err++;
      $display("FAIL ready_timeout got ready=%b want 1", bus.char_ready_o);
    end
    bus.char_i = c;
    bus.char_valid_i = 1'b1;
    @(posedge px_clk); #1;
    bus.char_valid_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge px_clk); #1;
  endtask

  task automatic chk_cursor(input string nm, input logic [5:0] x, input logic [4:0] y);
    n_cmp++;
    if (bus.cursor_x !== x || bus.cursor_y !== y) begin
      n_err++;
      $display("FAIL %s cursor got (%0d,%0d) want (%0d,%0d)", nm, bus.cursor_x, bus.cursor_y, x, y);
    end
  endtask

  task automatic chk_wr(input string nm, input logic we, input logic [10:0] a, input logic [7:0] d);
    n_cmp++;
    if (bus.we_vram !== we || (we && (bus.addr_vram !== a || bus.data_vram !== d))) begin
      n_err++;
      $display("FAIL %s we/addr/data got %b/%0d/%h want %b/%0d/%h", nm, bus.we_vram, bus.addr_vram, bus.data_vram, we, a, d);
    end
  endtask

  task automatic chk_ready(input string nm, input logic r);
    n_cmp++;
    if (bus.char_ready_o !== r) begin
      n_err++;
      $display("FAIL %s ready got %b want %b", nm, bus.char_ready_o, r);
    end
  endtask

  // Waits out a row clear (autoclear builds) checking the ascending blank writes.
  task automatic drain_line(input string nm, input logic [10:0] base);
`ifdef CONSOLE_AUTOCLEAR_EN
    int bad;
    bad = -1;
    for (int i = 0; i < 40; i++) begin
      if (bad < 0 && (bus.we_vram !== 1'b1 || bus.addr_vram !== base + 11'(i) || bus.data_vram !== 8'h20 || bus.char_ready_o !== 1'b0)) bad = i;
      tick();
    end
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s clear_line at step %0d got addr %0d want %0d", nm, bad, bus.addr_vram, base + 11'(bad));
    end
`endif
    chk_ready({nm, "_ready"}, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.char_valid_i = 1'b0;
    bus.char_i = 8'h00;
    repeat (3) @(posedge px_clk);
    #1;
    chk_wr("reset_wr", 1'b0, 11'd0, 8'h00);
    n_cmp++;
    if (bus.addr_vram !== 11'd0 || bus.data_vram !== 8'h00 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_regs addr/data/busy got %0d/%h/%b want 0/00/0", bus.addr_vram, bus.data_vram, bus.busy);
    end
    chk_cursor("reset_cursor", 6'd0, 5'd0);
    reset = 1'b0;
    tick();
    chk_ready("reset_ready", 1'b1);
  endtask

  task automatic test_print();
    send(8'h41);
    chk_wr("print_wr", 1'b1, 11'd0, 8'h41);
    chk_ready("print_ready_low", 1'b0);
    tick();
    chk_cursor("print_cursor", 6'd1, 5'd0);
    chk_ready("print_ready_back", 1'b1);
    chk_wr("print_we_off", 1'b0, 11'd0, 8'h00);
    n_cmp++;
    if (bus.addr_vram !== 11'd0 || bus.data_vram !== 8'h41) begin
      n_err++;
      $display("FAIL print_hold addr/data got %0d/%h want 0/41", bus.addr_vram, bus.data_vram);
    end
  endtask

  task automatic test_wrap();
    for (int i = 1; i < 39; i++) begin
      send(8'h61);
      tick();
    end
    chk_cursor("wrap_pre", 6'd39, 5'd0);
    send(8'h42);
    chk_wr("wrap_wr", 1'b1, 11'd39, 8'h42);
    tick();
    chk_cursor("wrap_cursor", 6'd0, 5'd1);
    drain_line("wrap", 11'd40);
  endtask

  task automatic test_ctrl();
    send(8'h0A);
    drain_line("lf1", 11'd80);
    send(8'h0A);
    drain_line("lf2", 11'd120);
    chk_cursor("lf_cursor", 6'd0, 5'd3);
    send(8'h08);
    chk_wr("bs0_nowr", 1'b0, 11'd0, 8'h00);
    chk_cursor("bs0_cursor", 6'd0, 5'd3);
    for (int i = 0; i < 17; i++) begin
      send(8'h78);
      tick();
    end
    send(8'h08);
    chk_cursor("bs_cursor", 6'd16, 5'd3);
    send(8'h0D);
    chk_cursor("cr_cursor", 6'd0, 5'd3);
    chk_ready("cr_ready", 1'b1);
    send(8'h07);
    chk_wr("bel_nowr", 1'b0, 11'd0, 8'h00);
    chk_cursor("bel_cursor", 6'd0, 5'd3);
    chk_ready("bel_ready", 1'b1);
  endtask

  task automatic test_row_wrap();
    for (int r = 3; r < 29; r++) begin
      send(8'h0A);
      drain_line("lfn", 11'(40 * (r + 1)));
    end
    for (int i = 0; i < 5; i++) begin
      send(8'h79);
      tick();
    end
    chk_cursor("rw_pre", 6'd5, 5'd29);
    send(8'h0A);
    chk_cursor("rw_cursor", 6'd0, 5'd0);
`ifdef CONSOLE_AUTOCLEAR_EN
    chk_wr("rw_wr", 1'b1, 11'd0, 8'h20);
`else
    chk_wr("rw_nowr", 1'b0, 11'd0, 8'h00);
`endif
    drain_line("rw", 11'd0);
  endtask

  task automatic test_clear_all();
    int i, bad;
    for (int r = 0; r < 7; r++) begin
      send(8'h0A);
      drain_line("ffpre", 11'(40 * (r + 1)));
    end
    for (int k = 0; k < 12; k++) begin
      send(8'h7A);
      tick();
    end
    chk_cursor("ff_pre", 6'd12, 5'd7);
    send(8'h0C);
    i = 0;
    bad = -1;
    while (bus.busy === 1'b1 && i < 2000) begin
      if (bad < 0 && (bus.we_vram !== 1'b1 || bus.addr_vram !== 11'(i) || bus.data_vram !== 8'h20)) bad = i;
      i++;
      tick();
    end
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL ff_seq at step %0d got addr %0d want %0d", bad, bus.addr_vram, bad);
    end
    n_cmp++;
    if (i != 1200) begin
      n_err++;
      $display("FAIL ff_len busy cycles got %0d want 1200", i);
    end
    chk_cursor("ff_cursor", 6'd0, 5'd0);
    chk_wr("ff_done", 1'b0, 11'd0, 8'h00);
    chk_ready("ff_ready", 1'b1);
  endtask

  task automatic test_reset_mid();
    send(8'h7A);
    tick();
    send(8'h0C);
    repeat (100) tick();
    #3;
    reset = 1'b1;
    #1;
    chk_wr("rst_mid_we", 1'b0, 11'd0, 8'h00);
    chk_cursor("rst_mid_cursor", 6'd0, 5'd0);
    #2;
    reset = 1'b0;
    tick();
    chk_ready("rst_mid_ready", 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_busy got %b want 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_print();
    test_wrap();
    test_ctrl();
    test_row_wrap();
    test_clear_all();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
